riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit sitting downstream of the control decoder and ALU in the execute stage. Takes a decoded load/store (write enable, byte select, funct3, ALU-computed address, rs2 data) and runs a req/gnt/rvalid transaction to data memory. Handles byte-lane alignment, load sign/zero extension, misalignment detection and bus timeout. Stalls the core until the access retires.

Parameters:
TIMEOUT, 16, cycles allowed in REQ or WAIT before bus error; 0 disables timeout
CNT_W, 8, width of timeout counter; TIMEOUT must be < 2**CNT_W

Ports:
i_clk  input  1  clock, all state on rising edge
i_rstn  input  1  synchronous active-low reset
i_lsu_valid  input  1  execute-stage instruction is a load/store
i_lsu_wr_en  input  1  1=store, 0=load (decoder mem_wr_en)
i_lsu_byte_sel  input  4  decoder byte select: 0001/0011/1111
i_lsu_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
i_lsu_addr  input  32  byte address from ALU
i_lsu_wdata  input  32  store data (rs2), right-aligned
o_lsu_stall  output  1  hold PC/pipeline
o_lsu_done  output  1  one-cycle retire pulse
o_lsu_rdata  output  32  extended load data, valid while o_lsu_done
o_lsu_misaligned  output  1  with o_lsu_done: access misaligned, no bus access
o_lsu_err  output  1  with o_lsu_done: bus timeout
o_lsu_mem_req  output  1  memory request
o_lsu_mem_we  output  1  memory write
o_lsu_mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
o_lsu_mem_be  output  4  lane byte enables
o_lsu_mem_wdata  output  32  lane-shifted store data
i_lsu_mem_gnt  input  1  request accepted this cycle
i_lsu_mem_rvalid  input  1  load data valid
i_lsu_mem_rdata  input  32  raw load word

Behaviour:
- Reset (i_rstn=0 at edge): state IDLE; all registered outputs 0 (req, we, addr, be, wdata, done, rdata, misaligned, err); timeout counter 0. Reset mid-transaction abandons it; late gnt/rvalid after reset are ignored in IDLE.
- o_lsu_stall = i_lsu_valid & ~o_lsu_done (combinational); all other outputs registered.
- offset = addr[1:0]. Misaligned: H/HU with offset[0]=1; W with offset!=0. Byte never misaligned.
- be = byte_sel << offset; wdata = i_lsu_wdata << (8*offset); addr, be, wdata, we, funct3, offset latched at acceptance and held stable while req=1.
- FSM IDLE/REQ/WAIT/DONE:
  - IDLE: valid & misaligned -> DONE, misaligned=1, no req. valid & aligned -> REQ, req=1 next cycle. Else stay.
  - REQ: req=1 until gnt sampled high. gnt & store -> DONE. gnt & load -> WAIT (req drops). Counter increments each REQ cycle.
  - WAIT: rvalid -> DONE, rdata = extend(i_lsu_mem_rdata >> 8*offset): B sign-ext bit7, BU zero-ext, H sign-ext bit15, HU zero-ext, W as-is. rvalid in same cycle as gnt is not supported (memory returns rvalid >= 1 cycle after gnt).
  - Counter reaches TIMEOUT (TIMEOUT!=0) in REQ or WAIT -> DONE, err=1, req=0, rdata=0. Counter clears on entry to REQ.
  - DONE: done=1 for exactly one cycle, -> IDLE unconditionally; valid ignored in DONE (it is the retiring instruction). Next access accepted in following IDLE cycle.
- Latency: aligned store with gnt on first req cycle: accept T, req T+1, done T+2. Load, gnt T+1, rvalid T+2: done T+3.
- misaligned/err/rdata cleared to 0 whenever done=0. Invalid funct3 (011,11x) treated as W.

Test Plan:
- Reset then sw 0xDEADBEEF to 0x100, gnt delayed 2 cycles -> req held 3 cycles, addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; done one cycle later; stall high until done.
- sb 0x000000A5 to 0x203 -> addr=0x200, be=1000, wdata=0xA5000000; lb at 0x103, rdata 0x80123456 -> o_lsu_rdata=0xFFFFFF80.
- lhu at 0x102, rdata 0x80010000 -> 0x00008001; lh same -> 0xFFFF8001; lw at 0x104 rdata 0x12345678 -> 0x12345678.
- sh to 0x101 and lw at 0x102 -> no req ever asserted, done+misaligned=1 one cycle after valid.
- TIMEOUT=16, gnt never asserted -> req high 16 cycles, then done+err=1, rdata=0, req=0; repeat with gnt but no rvalid -> err from WAIT.
- Reset asserted in WAIT, rvalid arrives next cycle -> state IDLE, no done pulse, all outputs 0; following load completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction per execute-stage load/store.
// Handles lane alignment, load extension, misalignment trap and bus timeout; stalls core until retire.
module riscv_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_wr_en,
  input  logic [3:0]  i_lsu_byte_sel,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  output logic        o_lsu_stall,
  output logic        o_lsu_done,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_misaligned,
  output logic        o_lsu_err,
  output logic        o_lsu_mem_req,
  output logic        o_lsu_mem_we,
  output logic [31:0] o_lsu_mem_addr,
  output logic [3:0]  o_lsu_mem_be,
  output logic [31:0] o_lsu_mem_wdata,
  input  logic        i_lsu_mem_gnt,
  input  logic        i_lsu_mem_rvalid,
  input  logic [31:0] i_lsu_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_offset;
  logic [2:0]        r_funct3;
  logic              r_req, r_we, r_done, r_misaligned, r_err;
  logic [31:0]       r_addr, r_wdata, r_rdata;
  logic [3:0]        r_be;

  logic [1:0]  w_off;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ext;
  logic        w_timeout;

  assign w_off   = i_lsu_addr[1:0];
  assign w_be    = i_lsu_byte_sel << w_off;
  assign w_wdata = i_lsu_wdata << {w_off, 3'b000};
  // funct3[1:0]: 00 byte, 01 half, anything else (incl. illegal encodings) is a word.
  assign w_misaligned = ((i_lsu_funct3[1:0] == 2'b01) && w_off[0]) ||
                        ((i_lsu_funct3[1:0] >= 2'b10) && (w_off != 2'b00));

  assign w_shift   = i_lsu_mem_rdata >> {r_offset, 3'b000};
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  always_comb begin
    w_ext = w_shift;
    case (r_funct3[1:0])
      2'b00:   w_ext = r_funct3[2] ? {24'b0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ext = r_funct3[2] ? {16'b0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_offset     <= '0;
      r_funct3     <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_lsu_valid) begin
            r_offset <= w_off;
            r_funct3 <= i_lsu_funct3;
            r_we     <= i_lsu_wr_en;
            r_addr   <= {i_lsu_addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_cnt    <= '0;
            if (w_misaligned) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_lsu_mem_gnt) begin
            r_req <= 1'b0;
            if (r_we) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        S_WAIT: begin
          // Timeout budget spans REQ and WAIT together; the counter is not cleared on gnt.
          r_cnt <= r_cnt + 1'b1;
          if (i_lsu_mem_rvalid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_ext;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lsu_stall      = i_lsu_valid & ~r_done;
  assign o_lsu_done       = r_done;
  assign o_lsu_rdata      = r_rdata;
  assign o_lsu_misaligned = r_misaligned;
  assign o_lsu_err        = r_err;
  assign o_lsu_mem_req    = r_req;
  assign o_lsu_mem_we     = r_we;
  assign o_lsu_mem_addr   = r_addr;
  assign o_lsu_mem_be     = r_be;
  assign o_lsu_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: directed accesses push expected retire/bus results,
// a monitor pops and compares whenever done or a req/gnt handshake appears.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, wr_en;
  logic [3:0]  byte_sel;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, misaligned, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  riscv_lsu #(.TIMEOUT(16), .CNT_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_lsu_valid(valid), .i_lsu_wr_en(wr_en), .i_lsu_byte_sel(byte_sel),
    .i_lsu_funct3(funct3), .i_lsu_addr(addr), .i_lsu_wdata(wdata),
    .o_lsu_stall(stall), .o_lsu_done(done), .o_lsu_rdata(rdata),
    .o_lsu_misaligned(misaligned), .o_lsu_err(err),
    .o_lsu_mem_req(mem_req), .o_lsu_mem_we(mem_we), .o_lsu_mem_addr(mem_addr),
    .o_lsu_mem_be(mem_be), .o_lsu_mem_wdata(mem_wdata),
    .i_lsu_mem_gnt(mem_gnt), .i_lsu_mem_rvalid(mem_rvalid), .i_lsu_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } done_exp_t;

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_exp_t;

  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [105:0] all_outs();
    return {mem_req, mem_we, mem_addr, mem_be, mem_wdata, done, rdata, misaligned, err, stall};
  endfunction

  // Monitor: samples 2 time units after the negedge where stimulus is driven.
  initial begin
    done_exp_t d;
    bus_exp_t  b;
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b1 && done === 1'b1) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = done_q.pop_front();
          chk({d.nm, "_rdata"}, rdata, d.rdata);
          chk({d.nm, "_misaligned"}, misaligned, d.mis);
          chk({d.nm, "_err"}, err, d.err);
          chk({d.nm, "_req_at_done"}, mem_req, 0);
        end
      end
      if (rstn === 1'b1 && mem_req === 1'b1 && mem_gnt === 1'b1) begin
        if (bus_q.size() == 0) chk("unexpected_grant", 1, 0);
        else begin
          b = bus_q.pop_front();
          chk({b.nm, "_bus"}, {mem_addr, mem_be, mem_wdata, mem_we}, {b.addr, b.be, b.wdata, b.we});
        end
      end
    end
  end

  // gnt_dly: req cycles seen before gnt (-1 never); rv_dly: cycles after gnt until rvalid (-1 never).
  task automatic access(input string nm, input logic we, input logic [3:0] bsel, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] mrd, input logic [31:0] e_rdata, input logic e_mis,
                        input logic e_err, input logic [31:0] e_baddr, input logic [3:0] e_be,
                        input logic [31:0] e_bwd, input int e_reqc, input int e_lat);
    done_exp_t d;
    bus_exp_t  b;
    int  cyc = 0;
    int  reqc = 0;
    int  since_gnt = -1;
    bit  done_seen = 0;
    bit  stall_ok = 1;
    @(negedge clk);
    valid = 1'b1; wr_en = we; byte_sel = bsel; funct3 = f3; addr = a; wdata = wd;
    d.nm = nm; d.rdata = e_rdata; d.mis = e_mis; d.err = e_err;
    done_q.push_back(d);
    if (gnt_dly >= 0 && e_reqc > 0) begin
      b.nm = nm; b.addr = e_baddr; b.be = e_be; b.wdata = e_bwd; b.we = we;
      bus_q.push_back(b);
    end
    while (!done_seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (done === 1'b1) begin
        done_seen = 1;
        if (stall !== 1'b0) stall_ok = 0;
      end else begin
        if (stall !== 1'b1) stall_ok = 0;
        if (mem_req === 1'b1) begin
          reqc++;
          if (gnt_dly >= 0 && reqc == gnt_dly + 1) begin
            mem_gnt = 1'b1; since_gnt = 0;
          end
        end else if (since_gnt >= 0) begin
          since_gnt++;
          if (rv_dly >= 0 && since_gnt == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = mrd;
          end
        end
      end
    end
    valid = 1'b0;
    chk({nm, "_completed"}, done_seen, 1);
    chk({nm, "_stall"}, stall_ok, 1);
    chk({nm, "_req_cycles"}, reqc, e_reqc);
    if (e_lat >= 0) chk({nm, "_latency"}, cyc, e_lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; valid = 1'b0; wr_en = 1'b0; byte_sel = '0; funct3 = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    rstn = 1'b1;

    //     name         we  bsel     f3      addr          wdata         gnt rv  mrd           e_rdata       mis err e_baddr       e_be     e_bwd         reqc lat
    access("sw",        1, 4'b1111, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 2, -1, 32'h0,        32'h0,        0, 0, 32'h0000_0100, 4'b1111, 32'hDEADBEEF, 3,  4);
    access("sb",        1, 4'b0001, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, -1, 32'h0,       32'h0,        0, 0, 32'h0000_0200, 4'b1000, 32'hA500_0000, 1, 2);
    access("lb",        0, 4'b0001, 3'b000, 32'h0000_0103, 32'h0,        0, 1, 32'h80123456,  32'hFFFFFF80, 0, 0, 32'h0000_0100, 4'b1000, 32'h0,        1,  3);
    access("lhu",       0, 4'b0011, 3'b101, 32'h0000_0102, 32'h0,        1, 2, 32'h80010000,  32'h00008001, 0, 0, 32'h0000_0100, 4'b1100, 32'h0,        2,  5);
    access("lh",        0, 4'b0011, 3'b001, 32'h0000_0102, 32'h0,        0, 1, 32'h80010000,  32'hFFFF8001, 0, 0, 32'h0000_0100, 4'b1100, 32'h0,        1,  3);
    access("lw",        0, 4'b1111, 3'b010, 32'h0000_0104, 32'h0,        0, 1, 32'h12345678,  32'h12345678, 0, 0, 32'h0000_0104, 4'b1111, 32'h0,        1,  3);
    access("lbu",       0, 4'b0001, 3'b100, 32'h0000_0101, 32'h0,        0, 3, 32'h0000F000,  32'h000000F0, 0, 0, 32'h0000_0100, 4'b0010, 32'h0,        1,  5);
    access("sh_mis",    1, 4'b0011, 3'b001, 32'h0000_0101, 32'h0000_1234, 0, -1, 32'h0,       32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,        0,  1);
    access("lw_mis",    0, 4'b1111, 3'b010, 32'h0000_0102, 32'h0,        0, 1, 32'h0,         32'h0,        1, 0, 32'h0,         4'b0000, 32'h0,        0,  1);
    access("to_req",    0, 4'b1111, 3'b010, 32'h0000_0104, 32'h0,       -1, -1, 32'h0,        32'h0,        0, 1, 32'h0,         4'b0000, 32'h0,        16, 17);
    access("to_wait",   0, 4'b1111, 3'b010, 32'h0000_0108, 32'h0,        0, -1, 32'h0,        32'h0,        0, 1, 32'h0000_0108, 4'b1111, 32'h0,        1,  -1);

    // Reset while waiting for load data; the late rvalid must be ignored.
    @(negedge clk);
    valid = 1'b1; wr_en = 1'b0; byte_sel = 4'b1111; funct3 = 3'b010; addr = 32'h0000_0104; wdata = '0;
    bus_q.push_back('{nm: "rst_wait", addr: 32'h0000_0104, be: 4'b1111, wdata: 32'h0, we: 1'b0});
    @(negedge clk);
    chk("rst_wait_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_wait_in_wait", {mem_req, done}, 2'b00);
    rstn = 1'b0; valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_wait_cleared", all_outs(), '0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("rst_wait_late_rvalid", all_outs(), '0);
    repeat (2) @(negedge clk);
    chk("rst_wait_idle", all_outs(), '0);

    access("lw_after",  0, 4'b1111, 3'b010, 32'h0000_010C, 32'h0,        0, 1, 32'hCAFEF00D,  32'hCAFEF00D, 0, 0, 32'h0000_010C, 4'b1111, 32'h0,        1,  3);

    repeat (3) @(negedge clk);
    chk("done_queue_drained", done_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
